// File: rtl/whack_pkg.sv
// rtl/whack_pkg.sv - shared sprite ROM geometry, pixel type and requester indices
package whack_pkg;

    localparam int SPRITE_AW = 15;
    localparam int SPRITE_DW = 12;

    typedef logic [SPRITE_DW-1:0] rgb444_t;

    localparam int REQ_VGA   = 0;
    localparam int REQ_HIT   = 1;
    localparam int REQ_MOLE  = 2;
    localparam int REQ_SCORE = 3;

endpackage

// File: rtl/mole_rom_arbiter_rr_pick.sv
// rtl/mole_rom_arbiter_rr_pick.sv - combinational round-robin one-hot picker
module rr_pick #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    always_comb begin : pick
        logic           found;
        int             idx;
        logic [IDW-1:0] idx_w;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_w = IDW'(idx);
            if (!found && req[idx_w]) begin
                found      = 1'b1;
                gnt[idx_w] = 1'b1;
                gnt_id     = idx_w;
            end
        end
    end

endmodule

// File: rtl/mole_rom_arbiter.sv
// rtl/mole_rom_arbiter.sv - round-robin sprite ROM arbiter with tagged response pipeline
// ROM_ARB_PRIO0_EN: requester 0 (VGA scan-out) takes absolute priority over the rotation.
module mole_rom_arbiter
    import whack_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int AW     = SPRITE_AW,
    parameter int DW     = SPRITE_DW,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*AW-1:0]       req_addr,
    output logic [NREQ-1:0]          gnt,
    output logic [AW-1:0]            rom_addr,
    input  logic [DW-1:0]            rom_data,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [DW-1:0]            rsp_data
);

    localparam int IDW   = $clog2(NREQ);
    // Stage 0 is the tag captured with rom_addr; the last stage drives rsp_valid/rsp_id.
    localparam int DEPTH = RD_LAT + 2;

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]    rom_addr_q, rom_addr_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [IDW-1:0]   id_q [DEPTH];
    logic [IDW-1:0]   id_d [DEPTH];
    logic [DW-1:0]    rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]  pick_req, pick_gnt;
    logic [IDW-1:0]   pick_id, gnt_id;
    logic             gnt_any, ptr_adv;

`ifdef ROM_ARB_PRIO0_EN
    assign pick_req = {req[NREQ-1:1], 1'b0};
`else
    assign pick_req = req;
`endif

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req    (pick_req),
        .ptr    (ptr_q),
        .gnt    (pick_gnt),
        .gnt_id (pick_id)
    );

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        ptr_adv = 1'b0;
        if (rst_n) begin
`ifdef ROM_ARB_PRIO0_EN
            if (req[0]) begin
                gnt[0]  = 1'b1;
                gnt_any = 1'b1;
            end else if (|pick_gnt) begin
                gnt     = pick_gnt;
                gnt_id  = pick_id;
                gnt_any = 1'b1;
                ptr_adv = 1'b1;
            end
`else
            if (|pick_gnt) begin
                gnt     = pick_gnt;
                gnt_id  = pick_id;
                gnt_any = 1'b1;
                ptr_adv = 1'b1;
            end
`endif
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        rom_addr_d = rom_addr_q;
        if (ptr_adv) begin
            ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
        if (gnt_any) begin
            rom_addr_d = req_addr[gnt_id*AW +: AW];
        end

        vld_d   = {vld_q[DEPTH-2:0], gnt_any};
        id_d[0] = gnt_any ? gnt_id : id_q[0];
        for (int k = 1; k < DEPTH; k++) begin
            id_d[k] = id_q[k-1];
        end

        // ROM output belongs to the grant about to reach the response stage.
        rsp_data_d = vld_q[DEPTH-2] ? rom_data : rsp_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            rom_addr_q <= '0;
            vld_q      <= '0;
            rsp_data_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                id_q[k] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            rom_addr_q <= rom_addr_d;
            vld_q      <= vld_d;
            rsp_data_q <= rsp_data_d;
            for (int k = 0; k < DEPTH; k++) begin
                id_q[k] <= id_d[k];
            end
        end
    end

    assign rom_addr  = rom_addr_q;
    assign rsp_valid = vld_q[DEPTH-1];
    assign rsp_id    = id_q[DEPTH-1];
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_mole_rom_arbiter.sv
// tb/tb_mole_rom_arbiter.sv - random and directed checks of two arbiter instances (RD_LAT 1 and 3)
module tb_mole_rom_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 15;
    localparam int DW   = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*AW-1:0] req_addr;

    logic [NREQ-1:0] gnt1, gnt3;
    logic [AW-1:0]   rom_addr1, rom_addr3;
    logic [DW-1:0]   rom_data1, rom_data3, rsp_data1, rsp_data3;
    logic            rsp_valid1, rsp_valid3;
    logic [1:0]      rsp_id1, rsp_id3;

    mole_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .gnt(gnt1),
        .rom_addr(rom_addr1), .rom_data(rom_data1), .rsp_valid(rsp_valid1),
        .rsp_id(rsp_id1), .rsp_data(rsp_data1)
    );

    mole_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .gnt(gnt3),
        .rom_addr(rom_addr3), .rom_data(rom_data3), .rsp_valid(rsp_valid3),
        .rsp_id(rsp_id3), .rsp_data(rsp_data3)
    );

    // ROM models: data = addr[11:0], delivered RD_LAT cycles after the address changes
    logic [AW-1:0] rp1;
    logic [AW-1:0] rp3 [3];
    always @(posedge clk) begin
        rp1    <= rom_addr1;
        rp3[0] <= rom_addr3;
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end
    assign rom_data1 = rp1[11:0];
    assign rom_data3 = rp3[2][11:0];

    int nvec = 0;
    int nerr = 0;

    int          mptr;
    logic [AW-1:0] m_addr;
    bit          rv [2][64];
    logic [1:0]  rid [2][64];
    logic [11:0] rd [2][64];
    logic [11:0] last_d [2];
    int          cyc;
    int          lat [2] = '{1, 3};

    int          ncall;
    int          last_w;
    logic [3:0]  g_seen;
    logic        v1_seen, v3_seen;
    logic [1:0]  id1_seen;
    logic [11:0] d1_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mptr   = 0;
        m_addr = '0;
        for (int j = 0; j < 2; j++) begin
            last_d[j] = '0;
            for (int s = 0; s < 64; s++) rv[j][s] = 1'b0;
        end
    endtask

    function automatic int model_pick(input logic [3:0] r);
        int idx;
`ifdef ROM_ARB_PRIO0_EN
        if (r[0]) return 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (mptr + k) % NREQ;
            if (idx != 0 && r[idx]) return idx;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            idx = (mptr + k) % NREQ;
            if (r[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    task automatic check_cycle(output int w);
        int slot;
        logic [3:0] eg;
        bit v;
        logic av;
        logic [1:0] aid;
        logic [11:0] ad;
        if (!rst_n) model_reset();
        w  = rst_n ? model_pick(req) : -1;
        eg = (w < 0) ? 4'b0 : 4'(1 << w);
        g_seen   = gnt1;
        v1_seen  = rsp_valid1;
        v3_seen  = rsp_valid3;
        id1_seen = rsp_id1;
        d1_seen  = rsp_data1;
        check("gnt1", 32'(gnt1), 32'(eg));
        check("gnt3", 32'(gnt3), 32'(eg));
        check("rom_addr1", 32'(rom_addr1), 32'(m_addr));
        check("rom_addr3", 32'(rom_addr3), 32'(m_addr));
        slot = cyc % 64;
        for (int j = 0; j < 2; j++) begin
            v = rv[j][slot];
            if (v) last_d[j] = rd[j][slot];
            av  = (j == 0) ? rsp_valid1 : rsp_valid3;
            aid = (j == 0) ? rsp_id1 : rsp_id3;
            ad  = (j == 0) ? rsp_data1 : rsp_data3;
            check(j == 0 ? "rsp_valid1" : "rsp_valid3", 32'(av), 32'(v));
            check(j == 0 ? "rsp_data1" : "rsp_data3", 32'(ad), 32'(last_d[j]));
            if (v) check(j == 0 ? "rsp_id1" : "rsp_id3", 32'(aid), 32'(rid[j][slot]));
            else if (!rst_n) check(j == 0 ? "rsp_id1_rst" : "rsp_id3_rst", 32'(aid), 32'd0);
            rv[j][slot] = 1'b0;
        end
    endtask

    task automatic advance(input int w);
        logic [AW-1:0] a;
        int s;
        cyc++;
        if (w >= 0) begin
            a      = req_addr[w*AW +: AW];
            m_addr = a;
`ifdef ROM_ARB_PRIO0_EN
            if (w != 0) mptr = (w + 1) % NREQ;
`else
            mptr = (w + 1) % NREQ;
`endif
            for (int j = 0; j < 2; j++) begin
                s = (cyc + lat[j] + 1) % 64;
                rv[j][s]  = 1'b1;
                rid[j][s] = 2'(w);
                rd[j][s]  = a[11:0];
            end
        end
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
    endtask

    task automatic drive_random(input int w);
        rst_n = ($urandom_range(0, 99) != 0);
        for (int i = 0; i < NREQ; i++) begin
            if (!req[i] || w == i) begin
                req[i] = ($urandom_range(0, 9) < 6);
                set_addr(i, AW'($urandom));
            end
        end
    endtask

    task automatic cycle(input bit rnd);
        int w;
        @(negedge clk);
        check_cycle(w);
        ncall++;
        @(posedge clk);
        advance(w);
        #1;
        last_w = w;
        if (rnd) drive_random(w);
    endtask

    logic [3:0] gs [8];
    logic [1:0] idq [$];
    int t0, fv1, fv3, cnt;

    initial begin
        rst_n = 1'b0;
        req = '0;
        req_addr = '0;
        cyc = 0;
        ncall = 0;
        model_reset();
        repeat (3) cycle(0);
        check("rst_rom_addr", 32'(rom_addr1), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid1), 32'd0);

        // single request, RD_LAT=1 timing and data
        rst_n = 1'b1;
        req = 4'b0001;
        set_addr(0, 15'h0010);
        cycle(0);
        check("r032_gnt", 32'(g_seen), 32'h1);
        req = 4'b0000;
        repeat (3) cycle(0);
        check("r032_valid", 32'(v1_seen), 32'd1);
        check("r032_id", 32'(id1_seen), 32'd0);
        check("r032_data", 32'(d1_seen), 32'h010);

        // all requesters held: rotation and contiguous responses
        rst_n = 1'b0;
        cycle(0);
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_addr(i, AW'(16'h0100 * (i + 1) + i));
        req = 4'b1111;
        fv1 = -1;
        fv3 = -1;
        idq.delete();
        t0 = ncall + 1;
        for (int k = 0; k < 16; k++) begin
            cycle(0);
            if (k < 8) gs[k] = g_seen;
            if (v1_seen) begin
                idq.push_back(id1_seen);
                if (fv1 < 0) fv1 = ncall;
            end
            if (v3_seen && fv3 < 0) fv3 = ncall;
            if (k < 7 && last_w >= 0) set_addr(last_w, AW'($urandom));
            if (k == 7) req = 4'b0000;
        end
        check("r033_lat1", 32'(fv1 - t0), 32'd3);
        check("r037_lat3", 32'(fv3 - t0), 32'd5);
        check("r033_nrsp", 32'(idq.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
`ifdef ROM_ARB_PRIO0_EN
            check("r036_gnt_all", 32'(gs[k]), 32'h1);
            if (k < idq.size()) check("r036_rsp_id", 32'(idq[k]), 32'd0);
`else
            check("r033_gnt_seq", 32'(gs[k]), 32'(1 << (k % 4)));
            if (k < idq.size()) check("r033_rsp_id", 32'(idq[k]), 32'(k % 4));
`endif
        end

        // wrap from ptr=3
        req = 4'b0100;
        cycle(0);
        req = 4'b1001;
        cycle(0);
`ifndef ROM_ARB_PRIO0_EN
        check("r034_gnt3", 32'(g_seen), 32'h8);
        req = 4'b0001;
        cycle(0);
        check("r034_wrap", 32'(g_seen), 32'h1);
`endif
        req = 4'b0000;
        repeat (6) cycle(0);

        // reset discards in-flight responses
        req = 4'b0010;
        cycle(0);
        rst_n = 1'b0;
        req = 4'b0000;
        cnt = 0;
        cycle(0);
        check("r035_rst_gnt", 32'(g_seen), 32'd0);
        check("r035_rst_data", 32'(d1_seen), 32'd0);
        cnt += int'(v1_seen) + int'(v3_seen);
        rst_n = 1'b1;
        repeat (5) begin
            cycle(0);
            cnt += int'(v1_seen) + int'(v3_seen);
        end
        check("r035_no_rsp", 32'(cnt), 32'd0);

`ifdef ROM_ARB_PRIO0_EN
        rst_n = 1'b0;
        cycle(0);
        rst_n = 1'b1;
        req = 4'b0111;
        repeat (4) begin
            cycle(0);
            check("r036_prio0", 32'(g_seen), 32'h1);
        end
        req = 4'b0110;
        cycle(0);
        check("r036_rr1", 32'(g_seen), 32'h2);
        req = 4'b0100;
        cycle(0);
        check("r036_rr2", 32'(g_seen), 32'h4);
        req = 4'b0000;
        repeat (6) cycle(0);
`endif

        // randomized traffic with occasional reset
        drive_random(-1);
        rst_n = 1'b1;
        repeat (800) cycle(1);
        req = 4'b0000;
        rst_n = 1'b1;
        repeat (8) cycle(0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
